// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe core and its automatic player.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ttt_pkg;

    // Player codes
    localparam logic [1:0] A    = 2'b01;
    localparam logic [1:0] B    = 2'b10;

    // Game status codes
    localparam logic [1:0] PLAY = 2'b00;
    localparam logic [1:0] Awin = 2'b01;
    localparam logic [1:0] Bwin = 2'b10;
    localparam logic [1:0] DRAW = 2'b11;

    // The eight winning lines as cell masks (bit i = cell i, row-major)
    localparam logic [7:0][8:0] LINES = {
        9'b001010100,   // diag {2,4,6}
        9'b100010001,   // diag {0,4,8}
        9'b100100100,   // col  {2,5,8}
        9'b010010010,   // col  {1,4,7}
        9'b001001001,   // col  {0,3,6}
        9'b111000000,   // row  {6,7,8}
        9'b000111000,   // row  {3,4,5}
        9'b000000111    // row  {0,1,2}
    };

    // Fallback preference: centre, corners, edges. Entry 0 is tried first.
    localparam logic [8:0][3:0] PREF_ORDER = {
        4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
    };

    // Bot FSM encoding
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SCAN_WIN   = 3'd1;
    localparam logic [2:0] ST_SCAN_BLOCK = 3'd2;
    localparam logic [2:0] ST_PICK       = 3'd3;
    localparam logic [2:0] ST_PULSE      = 3'd4;
    localparam logic [2:0] ST_WAIT_REL   = 3'd5;

endpackage

// File: rtl/ttt_line_check.sv
// Flags whether placing at free cell k would complete a line already two-thirds held in v.
// Latency: combinational.
// Backpressure: none.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0] v,
    input  logic [8:0] free,
    input  logic [3:0] k,
    output logic       completes
);

    logic [8:0] k_mask;
    logic [8:0] others;

    // Any line through k whose remaining two cells are both in v; k itself must be free
    always_comb begin
        completes = 1'b0;
        k_mask    = '0;
        others    = '0;
        if (k <= 4'd8) begin
            k_mask = 9'd1 << k;
        end
        for (int l = 0; l < 8; l++) begin
            others = LINES[l] & ~k_mask;
            if (((LINES[l] & k_mask) != 9'd0) && ((v & others) == others)) begin
                completes = 1'b1;
            end
        end
        if ((free & k_mask) == 9'd0) begin
            completes = 1'b0;
        end
    end

endmodule

// File: rtl/tic_tac_toe_bot.sv
// Automatic player: scans for a win, then a block, then a preferred free cell, and confirms with ok_btn.
// Latency: ok_btn rises k+2 cycles after go (win at k), k+11 (block at k), or 20 (preference pick).
// Backpressure: one move per go assertion; go must drop before another move is considered.
module tic_tac_toe_bot
    import ttt_pkg::*;
#(
    parameter logic [1:0] SIDE         = B,
    parameter int         OK_PULSE_LEN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] A_state,
    input  logic [8:0] B_state,
    input  logic [1:0] status,
    input  logic       go,
    input  logic       new_game,
    output logic [8:0] move_vec,
    output logic       ok_btn,
    output logic [3:0] move_cell,
    output logic       busy,
    output logic       err
);

    localparam logic [3:0] PULSE_LEN = 4'(OK_PULSE_LEN);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] move_vec_q, move_vec_d;
    logic [3:0] move_cell_q, move_cell_d;
    logic       ok_btn_q, ok_btn_d;

    logic [8:0] own, opp, free;
    logic       own_hit, opp_hit;
    logic [3:0] pick_cell;
    logic       commit_en;
    logic [3:0] commit_cell;
    logic       deciding;
    logic       abort;

    assign own   = (SIDE == A) ? A_state : B_state;
    assign opp   = (SIDE == A) ? B_state : A_state;
    assign free  = ~(A_state | B_state);
    assign err   = |(A_state & B_state);
    assign abort = (status != PLAY) || err;

    ttt_line_check u_own_check (.v(own), .free(free), .k(cnt_q), .completes(own_hit));
    ttt_line_check u_opp_check (.v(opp), .free(free), .k(cnt_q), .completes(opp_hit));

    // Preference encoder; later loop iterations are higher priority
    always_comb begin
        pick_cell = 4'hF;
        for (int i = 8; i >= 0; i--) begin
            if (free[PREF_ORDER[i]]) begin
                pick_cell = PREF_ORDER[i];
            end
        end
    end

    // Next-state logic: scan, commit, pulse, then wait for go to drop
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        move_vec_d  = move_vec_q;
        move_cell_d = move_cell_q;
        ok_btn_d    = ok_btn_q;
        commit_en   = 1'b0;
        commit_cell = cnt_q;
        deciding    = (state_q == ST_SCAN_WIN) || (state_q == ST_SCAN_BLOCK) || (state_q == ST_PICK);

        case (state_q)
            ST_IDLE: begin
                ok_btn_d = 1'b0;
                // Core cleared the board without new_game: forget our stale moves
                if ((own == 9'd0) && (move_vec_q != 9'd0)) begin
                    move_vec_d = '0;
                end
                if (go && (status == PLAY) && (free != 9'd0) && !err) begin
                    state_d = ST_SCAN_WIN;
                    cnt_d   = 4'd0;
                end
            end
            ST_SCAN_WIN, ST_SCAN_BLOCK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if ((state_q == ST_SCAN_WIN) ? own_hit : opp_hit) begin
                    commit_en = 1'b1;
                end else if (cnt_q == 4'd8) begin
                    state_d = (state_q == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_PICK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_PICK: begin
                if (abort || (free == 9'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    commit_en   = 1'b1;
                    commit_cell = pick_cell;
                end
            end
            ST_PULSE: begin
                // cnt counts cycles ok_btn has already been high, including this one
                if (cnt_q >= PULSE_LEN) begin
                    ok_btn_d = 1'b0;
                    state_d  = ST_WAIT_REL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT_REL: begin
                if (!go) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ok_btn_d = 1'b0;
            end
        endcase

        if (commit_en) begin
            move_vec_d  = move_vec_q | (9'd1 << commit_cell);
            move_cell_d = commit_cell;
            ok_btn_d    = 1'b1;
            cnt_d       = 4'd1;
            state_d     = ST_PULSE;
        end

        // new_game overrides a same-cycle commit but lets a running pulse finish
        if (new_game) begin
            move_vec_d  = '0;
            move_cell_d = 4'hF;
            if (deciding) begin
                state_d  = ST_IDLE;
                ok_btn_d = 1'b0;
                cnt_d    = 4'd0;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            move_vec_q  <= '0;
            move_cell_q <= 4'hF;
            ok_btn_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            move_vec_q  <= move_vec_d;
            move_cell_q <= move_cell_d;
            ok_btn_q    <= ok_btn_d;
        end
    end

    assign move_vec  = move_vec_q;
    assign move_cell = move_cell_q;
    assign ok_btn    = ok_btn_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tic_tac_toe_bot.sv
module tb_tic_tac_toe_bot;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] A_state, B_state;
    logic [1:0] status;
    logic       go, new_game;

    logic [8:0] move_vec, move_vec3;
    logic       ok_btn, ok_btn3;
    logic [3:0] move_cell, move_cell3;
    logic       busy, busy3;
    logic       err, err3;

    int passed = 0;
    int total  = 0;
    int n;
    int hi1, hi3, rise1, rise3;
    logic prev1, prev3;

    always #5 clk = ~clk;

    tic_tac_toe_bot #(.SIDE(2'b10), .OK_PULSE_LEN(1)) dut (
        .clk(clk), .reset(reset), .A_state(A_state), .B_state(B_state),
        .status(status), .go(go), .new_game(new_game),
        .move_vec(move_vec), .ok_btn(ok_btn), .move_cell(move_cell),
        .busy(busy), .err(err)
    );

    tic_tac_toe_bot #(.SIDE(2'b10), .OK_PULSE_LEN(3)) dut3 (
        .clk(clk), .reset(reset), .A_state(A_state), .B_state(B_state),
        .status(status), .go(go), .new_game(new_game),
        .move_vec(move_vec3), .ok_btn(ok_btn3), .move_cell(move_cell3),
        .busy(busy3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Ticks until ok_btn is seen high; n = cycles from go sample, or -1 if none within budget
    task automatic wait_ok(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ok_btn === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        reset = 1'b1; A_state = '0; B_state = '0; status = 2'b00; go = 1'b0; new_game = 1'b0;
        #1;
        check("rst_move_vec", move_vec, 9'd0);
        check("rst_ok_btn", ok_btn, 1'b0);
        check("rst_move_cell", move_cell, 4'hF);
        check("rst_busy", busy, 1'b0);
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // Win scan: B holds 0,1 -> take 2 at cycle 4
        A_state = 9'b000011000; B_state = 9'b000000011; go = 1'b1;
        wait_ok(40, n);
        check("win_latency", n, 4);
        check("win_cell", move_cell, 4'd2);
        check("win_vec", move_vec, 9'b000000100);
        check("win_cell_len3", move_cell3, 4'd2);
        go = 1'b0;
        ticks(6);
        check("win_idle", busy, 1'b0);

        // Board cleared by the core without new_game: stale move_vec dropped in IDLE
        A_state = '0; B_state = '0;
        ticks(2);
        check("own_clear_vec", move_vec, 9'd0);

        // Block: A threatens 0,1 -> block 2 at cycle 13, one-cycle pulse
        A_state = 9'b000000011; B_state = 9'b000010000; go = 1'b1;
        wait_ok(40, n);
        check("block_latency", n, 13);
        check("block_cell", move_cell, 4'd2);
        check("block_vec", move_vec, 9'b000000100);
        tick();
        check("block_pulse_w1", ok_btn, 1'b0);
        go = 1'b0;
        ticks(6);
        pulse_new_game();
        check("ng_vec", move_vec, 9'd0);
        check("ng_cell", move_cell, 4'hF);

        // Preference: empty board -> centre at cycle 20
        A_state = '0; B_state = '0; go = 1'b1;
        wait_ok(40, n);
        check("pref_empty_latency", n, 20);
        check("pref_empty_cell", move_cell, 4'd4);
        go = 1'b0;
        ticks(6);
        pulse_new_game();

        // Preference: centre taken by A -> corner 0
        A_state = 9'b000010000; B_state = '0; go = 1'b1;
        wait_ok(40, n);
        check("pref_c4_latency", n, 20);
        check("pref_c4_cell", move_cell, 4'd0);
        go = 1'b0;
        ticks(6);
        pulse_new_game();

        // Guard: game already won
        A_state = '0; B_state = '0; status = 2'b01; go = 1'b1;
        wait_ok(30, n);
        check("guard_awin_ok", n, -1);
        check("guard_awin_busy", busy, 1'b0);
        go = 1'b0; status = 2'b00;
        tick();

        // Guard: overlapping ownership
        A_state = 9'b000000001; B_state = 9'b000000001; go = 1'b1;
        tick();
        check("guard_err_flag", err, 1'b1);
        wait_ok(30, n);
        check("guard_err_ok", n, -1);
        check("guard_err_busy", busy, 1'b0);
        go = 1'b0;
        tick();

        // Guard: full board
        A_state = 9'b000011111; B_state = 9'b111100000; go = 1'b1;
        tick();
        check("guard_full_err", err, 1'b0);
        wait_ok(30, n);
        check("guard_full_ok", n, -1);
        check("guard_full_busy", busy, 1'b0);
        go = 1'b0;
        tick();

        // Abort: status leaves PLAY mid-scan
        A_state = '0; B_state = '0; go = 1'b1;
        ticks(5);
        check("abort_busy_before", busy, 1'b1);
        status = 2'b11;
        tick();
        check("abort_busy_after", busy, 1'b0);
        go = 1'b0; status = 2'b00;
        ticks(2);

        // Handshake: go held 50 cycles -> one pulse of each configured width
        hi1 = 0; hi3 = 0; rise1 = 0; rise3 = 0; prev1 = 1'b0; prev3 = 1'b0;
        go = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ok_btn)  hi1++;
            if (ok_btn3) hi3++;
            if (ok_btn  && !prev1) rise1++;
            if (ok_btn3 && !prev3) rise3++;
            prev1 = ok_btn;
            prev3 = ok_btn3;
        end
        check("hs_pulses_len1", rise1, 1);
        check("hs_width_len1", hi1, 1);
        check("hs_pulses_len3", rise3, 1);
        check("hs_width_len3", hi3, 3);
        check("hs_cell", move_cell, 4'd4);

        // Core accepts the move; then reset mid SCAN_BLOCK
        B_state = 9'b000010000; go = 1'b0;
        ticks(3);
        check("hs_vec_kept", move_vec, 9'b000010000);
        go = 1'b1;
        ticks(12);
        check("mid_block_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_vec", move_vec, 9'd0);
        check("rst_mid_cell", move_cell, 4'hF);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ok", ok_btn, 1'b0);
        go = 1'b0;
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // new_game in the commit cycle of a win at cell 2 (commit decided in cycle 3)
        A_state = 9'b000011000; B_state = 9'b000000011; go = 1'b1;
        ticks(3);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("ngc_vec", move_vec, 9'd0);
        check("ngc_ok", ok_btn, 1'b0);
        check("ngc_cell", move_cell, 4'hF);
        check("ngc_busy", busy, 1'b0);
        go = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
